// File: rtl/window_collector_26p.sv
// -----------------------------------------------------------------------------
// window_collector_26p
//
// Purpose:
//   Gathers a serial stream of DATA_W-bit sample words into one window of
//   TAPS+1 words. Words 0..TAPS-1 are packed into out_25P (word 0 in the LSBs)
//   and word TAPS becomes out_bias, ready to feed an adder tree. A
//   valid/ready handshake on both sides lets windows stream back-to-back with
//   no bubble when the consumer keeps up. A second internal copy of a finished
//   window is held (state FULL) while the output slot is still occupied.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   clear       in   synchronous discard of any partial or held window
//   in_data     in   [DATA_W]       serial sample word
//   in_valid    in   in_data is valid
//   in_ready    out  a word is accepted this cycle
//   out_25P     out  [TAPS*DATA_W]  packed lanes 0..TAPS-1
//   out_bias    out  [DATA_W]       bias word (word TAPS)
//   out_valid   out  out_25P/out_bias hold a complete window
//   out_ready   in   downstream consumes the window this cycle
//   out_ref_sum out  [DATA_W]       modulo-2^DATA_W sum of all window words
//                    (present only when WINDOW_COLLECTOR_SUM_EN is defined)
//
// Configuration macro: WINDOW_COLLECTOR_SUM_EN
// -----------------------------------------------------------------------------
module window_collector_26p #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [TAPS*DATA_W-1:0] out_25P,
    output logic [DATA_W-1:0]      out_bias,
    output logic                   out_valid,
`ifdef WINDOW_COLLECTOR_SUM_EN
    output logic [DATA_W-1:0]      out_ref_sum,
`endif
    input  logic                   out_ready
);

    localparam int CNT_W = $clog2(TAPS + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TAPS*DATA_W-1:0] lanes_q, lanes_d;
    logic [DATA_W-1:0]      bias_q, bias_d;
    logic [TAPS*DATA_W-1:0] outLanes_q, outLanes_d;
    logic [DATA_W-1:0]      outBias_q, outBias_d;
    logic                   outValid_q, outValid_d;
`ifdef WINDOW_COLLECTOR_SUM_EN
    logic [DATA_W-1:0]      sumAcc_q, sumAcc_d;
    logic [DATA_W-1:0]      outSum_q, outSum_d;
`endif

    logic slotFree;
    logic accept;
    logic lastWord;

    // The slot can take a new window if it is empty or being drained now.
    assign slotFree = !outValid_q || out_ready;
    assign in_ready = !rst && (state_q == COLLECT);
    assign accept   = in_valid && in_ready;
    assign lastWord = (cnt_q == CNT_W'(TAPS));

    // Next-state logic. Clear takes priority over everything on the input
    // side (including a held FULL window and a simultaneous accept) but never
    // touches a window already sitting on the output. In COLLECT, the output
    // drop on out_ready is written first so a same-edge load overrides it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lanes_d    = lanes_q;
        bias_d     = bias_q;
        outLanes_d = outLanes_q;
        outBias_d  = outBias_q;
        outValid_d = outValid_q;
`ifdef WINDOW_COLLECTOR_SUM_EN
        sumAcc_d   = sumAcc_q;
        outSum_d   = outSum_q;
`endif
        if (clear) begin
            state_d = COLLECT;
            cnt_d   = '0;
            if (out_ready) begin
                outValid_d = 1'b0;
            end
        end else if (state_q == FULL) begin
            if (slotFree) begin
                outLanes_d = lanes_q;
                outBias_d  = bias_q;
                outValid_d = 1'b1;
`ifdef WINDOW_COLLECTOR_SUM_EN
                outSum_d   = sumAcc_q;
`endif
                state_d    = COLLECT;
            end
        end else begin
            if (out_ready) begin
                outValid_d = 1'b0;
            end
            if (accept) begin
`ifdef WINDOW_COLLECTOR_SUM_EN
                // Word 0 restarts the running sum, so stale totals never leak.
                sumAcc_d = ((cnt_q == '0) ? '0 : sumAcc_q) + in_data;
`endif
                if (lastWord) begin
                    bias_d = in_data;
                    cnt_d  = '0;
                    if (slotFree) begin
                        // Bias bypasses bias_q so the window lands in one cycle.
                        outLanes_d = lanes_q;
                        outBias_d  = in_data;
                        outValid_d = 1'b1;
`ifdef WINDOW_COLLECTOR_SUM_EN
                        outSum_d   = sumAcc_d;
`endif
                    end else begin
                        state_d = FULL;
                    end
                end else begin
                    for (int k = 0; k < TAPS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            lanes_d[k*DATA_W +: DATA_W] = in_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            lanes_q    <= '0;
            bias_q     <= '0;
            outLanes_q <= '0;
            outBias_q  <= '0;
            outValid_q <= 1'b0;
`ifdef WINDOW_COLLECTOR_SUM_EN
            sumAcc_q   <= '0;
            outSum_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lanes_q    <= lanes_d;
            bias_q     <= bias_d;
            outLanes_q <= outLanes_d;
            outBias_q  <= outBias_d;
            outValid_q <= outValid_d;
`ifdef WINDOW_COLLECTOR_SUM_EN
            sumAcc_q   <= sumAcc_d;
            outSum_q   <= outSum_d;
`endif
        end
    end

    assign out_25P   = outLanes_q;
    assign out_bias  = outBias_q;
    assign out_valid = outValid_q;
`ifdef WINDOW_COLLECTOR_SUM_EN
    assign out_ref_sum = outSum_q;
`endif

endmodule

// File: doc/window_collector_26p.md
WINDOW_COLLECTOR_26P -- requirements
Module: window_collector_26p

Interface
REQ-001 Parameter DATA_W, default 16, width of one sample word and of each packed lane.
REQ-002 Parameter TAPS, default 25, number of data lanes packed before the bias word; the window is TAPS+1 words.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port clear  input  1  synchronous discard of any partial window.
REQ-006 Port in_data  input  DATA_W  serial sample word.
REQ-007 Port in_valid  input  1  in_data is valid this cycle.
REQ-008 Port in_ready  output  1  block accepts a word this cycle.
REQ-009 Port out_25P  output  TAPS*DATA_W  packed window feeding the adder tree in_25P input.
REQ-010 Port out_bias  output  DATA_W  bias word feeding the adder tree in_bias input.
REQ-011 Port out_valid  output  1  out_25P and out_bias hold a complete window.
REQ-012 Port out_ready  input  1  downstream consumes the window this cycle.

Function
REQ-013 A word is accepted on any rising edge where in_valid and in_ready are both 1.
REQ-014 Accepted word k (k = 0..TAPS-1) of a window lands in out_25P[k*DATA_W +: DATA_W], so lane 0 is the LSBs; word TAPS lands in out_bias.
REQ-015 Word counter cnt runs 0..TAPS: it increments per accepted word and returns to 0 when the window completes.
REQ-016 The state machine has two states: COLLECT (in_ready=1) and FULL (in_ready=0, all TAPS+1 words held internally).
REQ-017 Output slot is free when out_valid=0 or out_ready=1 in that cycle.
REQ-018 On accepting word TAPS with the slot free, the output registers load the window and out_valid=1 on the next cycle (latency 1 cycle); state stays COLLECT and cnt=0, giving zero-bubble back-to-back windows.
REQ-019 On accepting word TAPS with the slot not free, the state goes to FULL.
REQ-020 In FULL, the window transfers to the output on the first cycle the slot is free; the state returns to COLLECT the next cycle.
REQ-021 While out_valid=1 and out_ready=0, out_25P, out_bias and out_valid are held unchanged.
REQ-022 out_valid drops the cycle after out_ready=1 unless a new window transfers on that same edge.
REQ-023 clear=1 forces cnt=0 and state COLLECT, and drops any partial or FULL window; it does not affect a window already presented on the output.
REQ-024 When clear and an accept occur in the same cycle, clear wins and the word is dropped.
REQ-025 The block performs no arithmetic on samples; words are passed bit-exact.

Reset
REQ-026 When rst=1 at a clock edge: state=COLLECT, cnt=0, out_valid=0, out_25P=0, out_bias=0, internal buffer=0.
REQ-027 in_ready reads 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-028 Reset asserted mid-window discards all collected words; the next accepted word is word 0.

Configuration
REQ-029 Macro WINDOW_COLLECTOR_SUM_EN defined: adds port out_ref_sum (output, DATA_W), the modulo-2^DATA_W sum of all TAPS+1 window words.
REQ-030 out_ref_sum is registered alongside out_25P, is held under the same rules, and resets to 0.
REQ-031 Macro WINDOW_COLLECTOR_SUM_EN undefined: port out_ref_sum and its accumulator are absent; all other behaviour is identical.

Verification
REQ-032 Stream words 0..25 with out_ready=1 held -> one cycle after word 25: out_valid=1, lane k=k, out_bias=25, out_ref_sum=325 (0x0145).
REQ-033 Stream words -k (k=0..25) -> lane k=two's complement of -k, out_bias=0xFFE7, out_ref_sum=0xFEBB.
REQ-034 Two windows back-to-back with in_valid held high, out_ready=0 -> window 1 held on output, in_ready=0 after word 25 of window 2; raising out_ready for 1 cycle -> window 2 appears next cycle and in_ready=1.
REQ-035 Pulse clear after 10 words, then stream 26 words of value 7 -> out_valid only after those 26, all lanes=7, out_bias=7, out_ref_sum=182.
REQ-036 Assert rst after 13 words with an output window pending -> out_valid=0, all outputs 0; the next 26 words form a complete, correctly ordered window.
